// File: rtl/buzzer_sequencer.sv
// buzzer_sequencer
//   Queues notes written by the CPU and plays them one at a time on a buzzer
//   peripheral. Each note becomes three buzzer writes (FREQ, TIME, OUTPUT).
//   The sequencer then polls the buzzer's TIME register until it reaches zero
//   and moves on to the next queued note.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   addrIn, sizeDecode  CPU write address / byte enables (0 = no write)
//   dataIn              CPU write data
//   addrOut, dataOut    CPU read address / data (registered, 1-cycle latency)
//   bzAddrIn, bzSize,
//   bzDataIn            buzzer write port (bzSize = 0 means no write)
//   bzAddrOut           buzzer read address (always TIME)
//   bzDataOut           buzzer read data (registered inside the buzzer)
//
// CPU map (addr[1:0])
//   0 CTRL   [0] enable, [1] flush (self-clearing), [3:2] output select
//   1 NOTE   write pushes {duration[31:16], note[3:0]}; read peeks the head
//   2 STATUS [4:0] count, [5] empty, [6] full, [7] busy, [11:8] note,
//            [12] overflow (sticky)
//   3 reserved
module buzzer_sequencer #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  addrIn,
  input  logic [7:0]  addrOut,
  input  logic [3:0]  sizeDecode,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic [7:0]  bzAddrIn,
  output logic [3:0]  bzSize,
  output logic [31:0] bzDataIn,
  output logic [7:0]  bzAddrOut,
  input  logic [31:0] bzDataOut
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE, WR_FREQ, WR_TIME, WR_OUT, GUARD, POLL, STOP
  } state_t;

  state_t        state, state_nx;
  logic [19:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          enable, overflow, gcnt;
  logic [1:0]    outsel;
  logic [3:0]    curNote;
  logic [15:0]   curTime;
  logic [19:0]   head;
  logic          empty, full, ctrl_wr, flush, push_req, push, pop;
  logic [31:0]   status, rdata;
  logic          unused_ok;

  assign unused_ok = ^{addrIn[7:2], addrOut[7:2], dataIn[15:4]};

  assign bzAddrOut = 8'd1;

  assign head     = mem[rptr];
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign ctrl_wr  = sizeDecode[0] && (addrIn[1:0] == 2'd0);
  assign flush    = ctrl_wr && dataIn[1];
  assign push_req = (addrIn[1:0] == 2'd1) && (sizeDecode != 4'd0);
  // Flush wins over both queue operations so a coincident push is discarded.
  assign pop      = (state == IDLE) && enable && !empty && !flush;
  assign push     = push_req && !flush && (!full || pop);

  // Note storage, no reset needed: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {dataIn[31:16], dataIn[3:0]};
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable   <= 1'b0;
      outsel   <= '0;
      overflow <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        enable <= dataIn[0];
        outsel <= dataIn[3:2];
      end
      if (flush)
        overflow <= 1'b0;
      else if (push_req && full && !pop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gcnt    <= 1'b0;
      curNote <= '0;
      curTime <= '0;
    end else begin
      state <= state_nx;
      gcnt  <= (state == GUARD) ? ~gcnt : 1'b0;
      if (pop) begin
        curNote <= head[3:0];
        curTime <= head[19:4];
      end
    end
  end

  always_comb begin
    state_nx = state;
    bzAddrIn = '0;
    bzSize   = '0;
    bzDataIn = '0;
    case (state)
      IDLE:    if (pop && (head[19:4] != 16'd0)) state_nx = WR_FREQ;
      WR_FREQ: begin
        bzSize   = '1;
        bzDataIn = {28'd0, curNote};
        state_nx = WR_TIME;
      end
      WR_TIME: begin
        bzAddrIn = 8'd1;
        bzSize   = '1;
        bzDataIn = {16'd0, curTime};
        state_nx = WR_OUT;
      end
      WR_OUT: begin
        bzAddrIn = 8'd2;
        bzSize   = '1;
        bzDataIn = {30'd0, outsel};
        state_nx = GUARD;
      end
      GUARD:   if (gcnt) state_nx = POLL;
      POLL:    if (bzDataOut == 32'd0) state_nx = IDLE;
      STOP: begin
        bzAddrIn = 8'd1;
        bzSize   = '1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (flush && (state != IDLE)) state_nx = STOP;
  end

  always_comb begin
    status       = '0;
    status[4:0]  = 5'(count);
    status[5]    = empty;
    status[6]    = full;
    status[7]    = (state != IDLE);
    status[11:8] = (state == IDLE) ? 4'd0 : curNote;
    status[12]   = overflow;
    case (addrOut[1:0])
      2'd0:    rdata = {28'd0, outsel, 1'b0, enable};
      2'd1:    rdata = empty ? 32'd0 : {head[19:4], 12'd0, head[3:0]};
      2'd2:    rdata = status;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) dataOut <= '0;
    else     dataOut <= rdata;
  end

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Directed bench for buzzer_sequencer. A small buzzer model answers TIME
// reads and counts TIME down by one every TICK clocks (a shortened ms).
// All stimulus changes and samples happen on the falling edge.
module tb_buzzer_sequencer;
  localparam int TICK = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addrIn, addrOut, bzAddrIn, bzAddrOut;
  logic [3:0]  sizeDecode, bzSize;
  logic [31:0] dataIn, dataOut, bzDataIn, bzDataOut;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  logic [39:0] wlog [$];
  int          wcyc [$];
  logic [15:0] mtime;
  int          tick;
  logic [31:0] v;

  always #5 clk = ~clk;

  buzzer_sequencer #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst), .addrIn(addrIn), .addrOut(addrOut),
    .sizeDecode(sizeDecode), .dataIn(dataIn), .dataOut(dataOut),
    .bzAddrIn(bzAddrIn), .bzSize(bzSize), .bzDataIn(bzDataIn),
    .bzAddrOut(bzAddrOut), .bzDataOut(bzDataOut)
  );

  // Buzzer model plus a log of every buzzer write and its cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bzSize != 4'd0) begin
      wlog.push_back({bzAddrIn, bzDataIn});
      wcyc.push_back(cyc);
    end
    if (rst) begin
      mtime     <= '0;
      tick      <= 0;
      bzDataOut <= '0;
    end else begin
      bzDataOut <= {16'd0, mtime};
      if (bzSize != 4'd0 && bzAddrIn == 8'd1) begin
        mtime <= bzDataIn[15:0];
        tick  <= 0;
      end else if (mtime != 16'd0) begin
        if (tick == TICK - 1) begin
          tick  <= 0;
          mtime <= mtime - 16'd1;
        end else begin
          tick <= tick + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d);
    addrIn     = a;
    dataIn     = d;
    sizeDecode = 4'hF;
    @(negedge clk);
    sizeDecode = 4'h0;
  endtask

  task automatic cpu_rd(input logic [7:0] a, output logic [31:0] d);
    addrOut = a;
    @(negedge clk);
    d = dataOut;
  endtask

  task automatic wait_status(input string tag, input logic [31:0] exp, input int maxc);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < maxc; i++) begin
      cpu_rd(8'd2, s);
      if (s == exp) break;
    end
    check(tag, {8'd0, s}, {8'd0, exp});
  endtask

  initial begin
    rst = 1'b1; addrIn = '0; addrOut = '0; sizeDecode = '0; dataIn = '0;
    repeat (3) @(negedge clk);
    check("rst_bzsize", {36'd0, bzSize}, 40'd0);
    check("rst_bzaddrin", {32'd0, bzAddrIn}, 40'd0);
    check("rst_bzdatain", {8'd0, bzDataIn}, 40'd0);
    check("rst_bzaddrout", {32'd0, bzAddrOut}, 40'd1);
    check("rst_dataout", {8'd0, dataOut}, 40'd0);
    rst = 1'b0;
    cpu_rd(8'd2, v); check("rst_status", {8'd0, v}, 40'h20);
    cpu_rd(8'd1, v); check("empty_note_read", {8'd0, v}, 40'd0);

    // Single note 8 / 3 ms with output select 1.
    wlog.delete(); wcyc.delete();
    cpu_wr(8'd0, 32'h5);
    cpu_wr(8'd1, 32'h0003_0008);
    cpu_rd(8'd2, v); check("t1_status_queued", {8'd0, v}, 40'h001);
    cpu_rd(8'd2, v); check("t1_status_busy", {8'd0, v}, 40'h8A0);
    wait_status("t1_idle", 32'h20, 200);
    check("t1_nwrites", 40'(wlog.size()), 40'd3);
    if (wlog.size() == 3) begin
      check("t1_freq", wlog[0], {8'd0, 32'd8});
      check("t1_time", wlog[1], {8'd1, 32'd3});
      check("t1_out",  wlog[2], {8'd2, 32'd1});
      check("t1_consecutive", 40'(wcyc[2] - wcyc[0]), 40'd2);
    end
    cpu_rd(8'd0, v); check("t1_ctrl_read", {8'd0, v}, 40'h5);
    cpu_rd(8'd3, v); check("t1_reserved_read", {8'd0, v}, 40'd0);

    // 17 pushes while disabled: last one dropped, overflow sticky.
    cpu_wr(8'd0, 32'h0);
    for (int i = 0; i < 17; i++) cpu_wr(8'd1, {16'd1, 12'd0, 4'(i % 14 + 1)});
    cpu_rd(8'd2, v); check("t2_full_status", {8'd0, v}, 40'h1050);
    cpu_rd(8'd1, v); check("t2_peek_head", {8'd0, v}, 40'h0001_0001);
    wlog.delete(); wcyc.delete();
    cpu_wr(8'd0, 32'h1);
    wait_status("t2_drained", 32'h1020, 2000);
    check("t2_nwrites", 40'(wlog.size()), 40'd48);
    if (wlog.size() == 48)
      for (int i = 0; i < 16; i++)
        check("t2_order", wlog[3 * i], {8'd0, 28'd0, 4'(i % 14 + 1)});

    // Flush in IDLE clears overflow; zero-duration entry is skipped.
    cpu_wr(8'd0, 32'h3);
    cpu_rd(8'd2, v); check("t3_flush_idle", {8'd0, v}, 40'h20);
    wlog.delete(); wcyc.delete();
    cpu_wr(8'd1, 32'h0000_0009);
    cpu_wr(8'd1, 32'h0001_0005);
    wait_status("t3_idle", 32'h20, 200);
    check("t3_nwrites", 40'(wlog.size()), 40'd3);
    if (wlog.size() == 3) begin
      check("t3_freq", wlog[0], {8'd0, 32'd5});
      check("t3_time", wlog[1], {8'd1, 32'd1});
      check("t3_out",  wlog[2], {8'd2, 32'd0});
    end

    // Flush during POLL emits one TIME=0 write.
    cpu_wr(8'd1, 32'h0032_0007);
    cpu_wr(8'd1, 32'h0002_0006);
    repeat (30) @(negedge clk);
    cpu_rd(8'd2, v); check("t4_polling", {8'd0, v}, 40'h781);
    wlog.delete(); wcyc.delete();
    cpu_wr(8'd0, 32'h3);
    check("t4_stop_write", {bzAddrIn, bzSize, bzDataIn[27:0]}, {8'd1, 4'hF, 28'd0});
    @(negedge clk);
    check("t4_nwrites", 40'(wlog.size()), 40'd1);
    if (wlog.size() == 1) check("t4_stop_entry", wlog[0], {8'd1, 32'd0});
    cpu_rd(8'd2, v); check("t4_status", {8'd0, v}, 40'h20);

    // Disable during note 2 of 3, then resume.
    cpu_wr(8'd0, 32'h0);
    wlog.delete(); wcyc.delete();
    cpu_wr(8'd1, 32'h0003_0001);
    cpu_wr(8'd1, 32'h0003_0002);
    cpu_wr(8'd1, 32'h0003_0003);
    cpu_wr(8'd0, 32'h1);
    v = '0;
    for (int i = 0; i < 200; i++) begin
      cpu_rd(8'd2, v);
      if (v[11:8] == 4'd2) break;
    end
    check("t5_note2_started", {36'd0, v[11:8]}, 40'd2);
    cpu_wr(8'd0, 32'h0);
    wait_status("t5_paused", 32'h01, 200);
    repeat (20) @(negedge clk);
    cpu_rd(8'd2, v); check("t5_still_paused", {8'd0, v}, 40'h01);
    cpu_wr(8'd0, 32'h1);
    wait_status("t5_resumed_idle", 32'h20, 200);
    check("t5_nwrites", 40'(wlog.size()), 40'd9);
    if (wlog.size() == 9)
      for (int i = 0; i < 3; i++)
        check("t5_order", wlog[3 * i], {8'd0, 28'd0, 4'(i + 1)});

    // Reset during WR_TIME aborts without a STOP write.
    wlog.delete(); wcyc.delete();
    cpu_wr(8'd1, 32'h0005_0004);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bzAddrIn == 8'd1 && bzSize == 4'hF) break;
    end
    check("t6_in_wr_time", {bzAddrIn, bzSize, bzDataIn[27:0]}, {8'd1, 4'hF, 28'd5});
    rst = 1'b1;
    @(negedge clk);
    check("t6_bz_reset", {bzAddrIn, bzSize, bzDataIn[27:0]}, 40'd0);
    check("t6_bzaddrout", {32'd0, bzAddrOut}, 40'd1);
    check("t6_dataout", {8'd0, dataOut}, 40'd0);
    rst = 1'b0;
    cpu_rd(8'd2, v); check("t6_status", {8'd0, v}, 40'h20);
    cpu_rd(8'd0, v); check("t6_ctrl", {8'd0, v}, 40'd0);
    repeat (5) @(negedge clk);
    check("t6_nwrites", 40'(wlog.size()), 40'd2);
    if (wlog.size() == 2) check("t6_last_write", wlog[1], {8'd1, 32'd5});

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
